// File: rtl/cga_comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cga_comp_pkg
//  Description : Shared constants, types and the burst-window compare helper
//                for the CGA composite decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cga_comp_pkg;

    // Default thresholds, overridable per instance.
    localparam int c_sync_th_def     = 15;
    localparam int c_vs_min_def      = 192;
    localparam int c_vs_end_def      = 128;
    localparam int c_burst_start_def = 16;
    localparam int c_burst_min_def   = 64;

    // Burst window length in samples: 8 subcarrier cycles of 4 samples.
    localparam int c_burst_len = 32;

    // 8 samples per phase of at most 127 each fit in 10 bits.
    localparam int c_acc_w  = 10;
    localparam int c_line_w = 10;
    localparam int c_run_w  = 9;

    typedef logic [c_acc_w-1:0]  acc_t;
    typedef logic [c_line_w-1:0] line_t;
    typedef logic [c_line_w:0]   line_ext_t;
    typedef logic [c_run_w-1:0]  run_t;

    // True while line_idx lies inside [start, start + c_burst_len). The upper
    // bound is evaluated one bit wider so a late start cannot wrap.
    function automatic logic in_burst_window(input line_t line_idx, input line_t start);
        return (line_idx >= start) &&
               ({1'b0, line_idx} < ({1'b0, start} + line_ext_t'(c_burst_len)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cga_burst_lock.sv
`default_nettype none
// ============================================================================
//  Module      : cga_burst_lock
//  Description : Per-phase colour-burst accumulators, window gating and the
//                argmax/spread decision that yields burst_phase and
//                colour_valid, held from one window close to the next.
//  Revision    : 1.0 - initial release
// ============================================================================
module cga_burst_lock
    import cga_comp_pkg::*;
#(
    parameter int BURST_START = c_burst_start_def,
    parameter int BURST_MIN   = c_burst_min_def
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [6:0] sample,
    input  logic [1:0] ph,
    input  line_t      line_idx,
    input  logic       sync_end,
    output logic [1:0] burst_phase,
    output logic       colour_valid
);

    localparam line_t     c_start      = line_t'(BURST_START);
    localparam line_ext_t c_close      = line_ext_t'(BURST_START + c_burst_len);
    localparam acc_t      c_min_spread = acc_t'(BURST_MIN);

    acc_t       r_acc [4];
    logic [1:0] r_burst_phase;
    logic       r_colour_valid;

    logic       w_in_window;
    logic       w_close;
    acc_t       w_max;
    acc_t       w_min;
    logic [1:0] w_arg;

    assign w_in_window = in_burst_window(line_idx, c_start);
    // The close sample is the first one past the window, so the accumulators
    // already hold their final totals when it arrives.
    assign w_close     = ({1'b0, line_idx} == c_close);

    // Sum burst samples into the accumulator of their subcarrier phase; every line restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
            end
        end else if (sample_en) begin
            if (sync_end) begin
                for (int i = 0; i < 4; i++) begin
                    r_acc[i] <= '0;
                end
            end else if (w_in_window) begin
                r_acc[ph] <= r_acc[ph] + acc_t'(sample);
            end
        end
    end

    // Find the strongest phase (lowest index wins a tie) and the weakest level.
    always_comb begin
        w_max = r_acc[0];
        w_min = r_acc[0];
        w_arg = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (r_acc[i] > w_max) begin
                w_max = r_acc[i];
                w_arg = 2'(i);
            end
            if (r_acc[i] < w_min) begin
                w_min = r_acc[i];
            end
        end
    end

    // Latch the lock decision only at window close; it holds across lines without a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_phase  <= 2'd0;
            r_colour_valid <= 1'b0;
        end else if (sample_en && w_close) begin
            r_burst_phase  <= w_arg;
            r_colour_valid <= ((w_max - w_min) >= c_min_spread);
        end
    end

    assign burst_phase  = r_burst_phase;
    assign colour_valid = r_colour_valid;

endmodule
`default_nettype wire

// File: rtl/cga_composite_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : cga_composite_decoder
//  Description : Recovers hsync/vsync, colour-burst lock, luma and the CGA
//                artifact-colour index from a 7-bit composite sample stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module cga_composite_decoder
    import cga_comp_pkg::*;
#(
    parameter int SYNC_TH     = c_sync_th_def,
    parameter int VS_MIN      = c_vs_min_def,
    parameter int VS_END      = c_vs_end_def,
    parameter int BURST_START = c_burst_start_def,
    parameter int BURST_MIN   = c_burst_min_def
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [6:0] comp_video,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       colour_valid,
    output logic [1:0] burst_phase,
    output logic [6:0] luma,
    output logic [3:0] artifact_idx,
    output logic       pix_valid
);

    localparam logic [6:0] c_sync_th  = 7'(SYNC_TH);
    localparam run_t       c_vs_min   = run_t'(VS_MIN);
    localparam run_t       c_vs_end   = run_t'(VS_END);
    localparam run_t       c_run_max  = '1;
    localparam line_t      c_line_max = '1;

    logic [1:0] r_ph;
    logic       r_hsync;
    run_t       r_run_cnt;
    line_t      r_line_cnt;
    logic       r_vsync;
    logic [6:0] r_hist [3];
    logic [6:0] r_luma;
    logic [3:0] r_artifact;
    logic       r_pix_valid;

    logic       w_sync_lvl;
    logic       w_sync_end;
    run_t       w_run_next;
    line_t      w_line_next;
    logic       w_vsync_next;
    logic [6:0] w_samp [4];
    logic [8:0] w_sum;
    logic [3:0] w_b;
    logic [3:0] w_idx;
    logic       w_blank;

    assign w_sync_lvl = (comp_video < c_sync_th);
    // r_hsync doubles as the previous sample's sync level.
    assign w_sync_end = r_hsync & ~w_sync_lvl;

    // Run length of the current sync/non-sync level, counting the current sample.
    always_comb begin
        w_run_next = r_run_cnt;
        if (w_sync_lvl != r_hsync) begin
            w_run_next = run_t'(1);
        end else if (r_run_cnt != c_run_max) begin
            w_run_next = r_run_cnt + run_t'(1);
        end
    end

    // Sample index within the line, zero on the first sample after sync.
    always_comb begin
        w_line_next = r_line_cnt;
        if (w_sync_end) begin
            w_line_next = '0;
        end else if (r_line_cnt != c_line_max) begin
            w_line_next = r_line_cnt + line_t'(1);
        end
    end

    // Long sync runs start vertical sync; only a long non-sync run ends it, so serrations pass.
    always_comb begin
        w_vsync_next = r_vsync;
        if (w_sync_lvl && (w_run_next >= c_vs_min)) begin
            w_vsync_next = 1'b1;
        end else if (!w_sync_lvl && (w_run_next >= c_vs_end)) begin
            w_vsync_next = 1'b0;
        end
    end

    // Sync separator state. The line counter leaves reset saturated so no burst
    // window can open until a real sync edge gives a line reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph       <= 2'd0;
            r_hsync    <= 1'b0;
            r_run_cnt  <= '0;
            r_line_cnt <= c_line_max;
            r_vsync    <= 1'b0;
        end else if (sample_en) begin
            r_ph       <= r_ph + 2'd1;
            r_hsync    <= w_sync_lvl;
            r_run_cnt  <= w_run_next;
            r_line_cnt <= w_line_next;
            r_vsync    <= w_vsync_next;
        end
    end

    cga_burst_lock #(
        .BURST_START (BURST_START),
        .BURST_MIN   (BURST_MIN)
    ) u_burst_lock (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .sample       (comp_video),
        .ph           (r_ph),
        .line_idx     (w_line_next),
        .sync_end     (w_sync_end),
        .burst_phase  (burst_phase),
        .colour_valid (colour_valid)
    );

    // Four most recent samples, newest (the one arriving now) first.
    assign w_samp[0] = comp_video;
    assign w_samp[1] = r_hist[0];
    assign w_samp[2] = r_hist[1];
    assign w_samp[3] = r_hist[2];

    assign w_sum = 9'(w_samp[0]) + 9'(w_samp[1]) + 9'(w_samp[2]) + 9'(w_samp[3]);

    // A sample is "high" when it exceeds the 4-sample average.
    for (genvar k = 0; k < 4; k++) begin : g_bits
        assign w_b[k] = ({w_samp[k], 2'b00} > w_sum);
    end

    // Sample s_k carries phase (ph - k); bit j picks the sample at phase burst_phase + j.
    for (genvar j = 0; j < 4; j++) begin : g_idx
        assign w_idx[j] = w_b[r_ph - burst_phase - 2'(j)];
    end

    assign w_blank = w_sync_lvl | w_vsync_next;

    // Pixel history and blanked luma / artifact index outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_hist[i] <= '0;
            end
            r_luma     <= '0;
            r_artifact <= '0;
        end else if (sample_en) begin
            r_hist[0]  <= w_samp[0];
            r_hist[1]  <= w_samp[1];
            r_hist[2]  <= w_samp[2];
            r_luma     <= w_blank ? 7'd0 : w_sum[8:2];
            r_artifact <= (w_blank || !colour_valid) ? 4'd0 : w_idx;
        end
    end

    // pix_valid is a plain one-clock delay of the sample strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= sample_en;
        end
    end

    assign hsync_out    = r_hsync;
    assign vsync_out    = r_vsync;
    assign luma         = r_luma;
    assign artifact_idx = r_artifact;
    assign pix_valid    = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_cga_composite_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cga_composite_decoder
//  Description : Directed, scoreboard-checked bench for cga_composite_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cga_composite_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [6:0] comp_video;
    logic       hsync_out;
    logic       vsync_out;
    logic       colour_valid;
    logic [1:0] burst_phase;
    logic [6:0] luma;
    logic [3:0] artifact_idx;
    logic       pix_valid;

    typedef struct {
        logic       hs;
        logic       vs;
        logic [6:0] luma;
        logic [3:0] art;
    } exp_t;

    exp_t       sb [$];
    exp_t       cur;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       se_d     = 1'b0;

    // Bench reference state: sample phase, last sample seen per phase,
    // and the expected vsync / lock values.
    int         tb_ph = 0;
    int         tb_bp = 0;
    logic       tb_cv = 1'b0;
    logic       tb_vs = 1'b0;
    logic [6:0] hp [4];

    cga_composite_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .comp_video   (comp_video),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .colour_valid (colour_valid),
        .burst_phase  (burst_phase),
        .luma         (luma),
        .artifact_idx (artifact_idx),
        .pix_valid    (pix_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) se_d <= sample_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Per-sample output check against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("pix_valid_delay", 32'(pix_valid), 32'(se_d));
            if (pix_valid) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL scoreboard_underflow observed=%0d expected=%0d", 0, 1);
                end
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    check("hsync_out", 32'(hsync_out), 32'(cur.hs));
                    check("vsync_out", 32'(vsync_out), 32'(cur.vs));
                    check("luma", 32'(luma), 32'(cur.luma));
                    check("artifact_idx", 32'(artifact_idx), 32'(cur.art));
                end
            end
        end
    end

    task automatic model_reset();
        tb_ph = 0;
        tb_bp = 0;
        tb_cv = 1'b0;
        tb_vs = 1'b0;
        for (int i = 0; i < 4; i++) hp[i] = 7'd0;
    endtask

    // Drive one sample (called on a negedge, returns on a negedge one idle cycle later).
    task automatic send(input logic [6:0] v);
        exp_t       e;
        int         s;
        logic [3:0] a;
        hp[tb_ph] = v;
        s = int'(hp[0]) + int'(hp[1]) + int'(hp[2]) + int'(hp[3]);
        e.hs = (v < 7'd15);
        e.vs = tb_vs;
        for (int j = 0; j < 4; j++) a[j] = ((4 * int'(hp[(tb_bp + j) % 4])) > s);
        e.luma = (e.hs || e.vs) ? 7'd0 : 7'(s / 4);
        e.art  = (e.hs || e.vs || !tb_cv) ? 4'd0 : a;
        sb.push_back(e);
        comp_video = v;
        sample_en  = 1'b1;
        @(negedge clk);
        sample_en  = 1'b0;
        tb_ph      = (tb_ph + 1) % 4;
        @(negedge clk);
    endtask

    task automatic sync_pulse();
        for (int i = 0; i < 64; i++) send(7'd0);
    endtask

    // Line start through window close; burst is 88 on phases 2,3 and 32 on 0,1.
    task automatic burst_region(input logic with_burst);
        for (int n = 0; n <= 48; n++) begin
            if (with_burst && n >= 16 && n < 48) send((tb_ph >= 2) ? 7'd88 : 7'd32);
            else                                   send(7'd60);
            if (n == 47) check("colour_valid_before_close", 32'(colour_valid), 32'(tb_cv));
        end
    endtask

    // Active pattern: 100 on two adjacent phases starting at hi_ph, 30 elsewhere.
    task automatic pattern(input int nsamp, input int hi_ph, input logic [3:0] exp_art);
        for (int i = 0; i < nsamp; i++) begin
            send((tb_ph == hi_ph || tb_ph == (hi_ph + 1) % 4) ? 7'd100 : 7'd30);
            if (i >= 3) begin
                check("pattern_luma", 32'(luma), 32'd65);
                check("pattern_artifact_idx", 32'(artifact_idx), 32'(exp_art));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hsync"}, 32'(hsync_out), 32'd0);
        check({tag, "_vsync"}, 32'(vsync_out), 32'd0);
        check({tag, "_colour_valid"}, 32'(colour_valid), 32'd0);
        check({tag, "_burst_phase"}, 32'(burst_phase), 32'd0);
        check({tag, "_luma"}, 32'(luma), 32'd0);
        check({tag, "_artifact_idx"}, 32'(artifact_idx), 32'd0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        sample_en  = 1'b0;
        comp_video = 7'd0;
        model_reset();

        // Reset held with live random input.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sample_en  = (i % 2 == 0);
            comp_video = 7'($urandom_range(0, 127));
            if (i >= 2) check_all_zero("in_reset");
        end
        sample_en = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");

        // Horizontal sync: 64 sync samples then a flat active line.
        sync_pulse();
        for (int i = 0; i < 848; i++) send(7'd60);
        check("flat_line_colour_valid", 32'(colour_valid), 32'd0);
        check("flat_line_burst_phase", 32'(burst_phase), 32'd0);

        // Burst lock then artifact patterns.
        sync_pulse();
        burst_region(1'b1);
        tb_cv = 1'b1;
        tb_bp = 2;
        check("lock_colour_valid", 32'(colour_valid), 32'd1);
        check("lock_burst_phase", 32'(burst_phase), 32'd2);
        pattern(40, 2, 4'b0011);
        pattern(40, 1, 4'b1001);

        // Reset in the middle of the active region.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("midline_reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        pattern(20, 2, 4'b0000);
        check("no_lock_after_reset", 32'(colour_valid), 32'd0);

        // Next line regains lock.
        sync_pulse();
        burst_region(1'b1);
        tb_cv = 1'b1;
        tb_bp = 2;
        check("relock_colour_valid", 32'(colour_valid), 32'd1);
        check("relock_burst_phase", 32'(burst_phase), 32'd2);
        pattern(12, 2, 4'b0011);

        // Flat burst: colour invalid, index forced to zero.
        sync_pulse();
        burst_region(1'b0);
        tb_cv = 1'b0;
        tb_bp = 0;
        check("flat_burst_colour_valid", 32'(colour_valid), 32'd0);
        check("flat_burst_burst_phase", 32'(burst_phase), 32'd0);
        pattern(12, 2, 4'b0000);

        // Vertical sync with serrations.
        for (int i = 0; i < 300; i++) begin
            tb_vs = (i >= 191);
            send(7'd0);
            if (i == 190) check("vsync_before_min", 32'(vsync_out), 32'd0);
            if (i == 191) check("vsync_at_min", 32'(vsync_out), 32'd1);
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) send(7'd60);
            check("vsync_serration", 32'(vsync_out), 32'd1);
            for (int i = 0; i < 800; i++) send(7'd0);
        end
        for (int i = 0; i < 136; i++) begin
            tb_vs = (i < 127);
            send(7'd60);
            if (i == 126) check("vsync_before_end", 32'(vsync_out), 32'd1);
            if (i == 127) check("vsync_at_end", 32'(vsync_out), 32'd0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
